// File: rtl/calc2_pkg.sv
// Shared command/response encodings and FSM state type for the calc2 requester port.
package calc2_pkg;

  localparam int unsigned CMD_W  = 4;
  localparam int unsigned RESP_W = 2;

  localparam logic [CMD_W-1:0] CMD_NOP = 4'd0;
  localparam logic [CMD_W-1:0] CMD_ADD = 4'd1;
  localparam logic [CMD_W-1:0] CMD_SUB = 4'd2;
  localparam logic [CMD_W-1:0] CMD_SHL = 4'd5;
  localparam logic [CMD_W-1:0] CMD_SHR = 4'd6;

  localparam logic [RESP_W-1:0] RESP_NONE    = 2'd0;
  localparam logic [RESP_W-1:0] RESP_OK      = 2'd1;
  localparam logic [RESP_W-1:0] RESP_ERR     = 2'd2;
  localparam logic [RESP_W-1:0] RESP_TIMEOUT = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DRV1 = 2'd1,
    ST_DRV2 = 2'd2
  } state_e;

  // Any non-zero response code from the DUT is a real response, including 3.
  function automatic logic resp_present(input logic [RESP_W-1:0] resp);
    return resp != RESP_NONE;
  endfunction

endpackage

// File: rtl/calc2_req_port_if.sv
// Operation, calc2 request/response and result signals of one requester port.
interface calc2_req_port_if
  import calc2_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned TAG_W  = 2
);
  localparam int unsigned NUM_TAGS = 1 << TAG_W;

  logic                op_valid;
  logic                op_ready;
  logic [CMD_W-1:0]    op_cmd;
  logic [DATA_W-1:0]   op_data1;
  logic [DATA_W-1:0]   op_data2;

  logic [CMD_W-1:0]    req_cmd_out;
  logic [DATA_W-1:0]   req_data_out;
  logic [TAG_W-1:0]    req_tag_out;

  logic [RESP_W-1:0]   resp_in;
  logic [DATA_W-1:0]   resp_data_in;
  logic [TAG_W-1:0]    resp_tag_in;

  logic                res_valid;
  logic [RESP_W-1:0]   res_resp;
  logic [DATA_W-1:0]   res_data;
  logic [TAG_W-1:0]    res_tag;
  logic [CMD_W-1:0]    res_cmd;
  logic [NUM_TAGS-1:0] busy_tags;
  logic                err_timeout;
  logic                err_unexpected;

  // Requester side: the calc2_req_port itself.
  modport master (
    input  op_valid, op_cmd, op_data1, op_data2,
    input  resp_in, resp_data_in, resp_tag_in,
    output op_ready,
    output req_cmd_out, req_data_out, req_tag_out,
    output res_valid, res_resp, res_data, res_tag, res_cmd,
    output busy_tags, err_timeout, err_unexpected
  );

  // Environment side: traffic source, DUT pins and result sink.
  modport slave (
    output op_valid, op_cmd, op_data1, op_data2,
    output resp_in, resp_data_in, resp_tag_in,
    input  op_ready,
    input  req_cmd_out, req_data_out, req_tag_out,
    input  res_valid, res_resp, res_data, res_tag, res_cmd,
    input  busy_tags, err_timeout, err_unexpected
  );

endinterface

// File: rtl/calc2_tag_pool.sv
// Outstanding-tag bitmap with lowest-free allocation and single-tag release.
module calc2_tag_pool #(
  parameter  int unsigned TAG_W    = 2,
  localparam int unsigned NUM_TAGS = 1 << TAG_W
) (
  input  logic                c_clk,
  input  logic                reset,
  input  logic                alloc_en,
  input  logic                release_en,
  input  logic [TAG_W-1:0]    release_tag,
  output logic [TAG_W-1:0]    alloc_tag,
  output logic                any_free,
  output logic [NUM_TAGS-1:0] busy
);

  logic [NUM_TAGS-1:0] busy_q;
  logic [NUM_TAGS-1:0] busy_d;

  // Lowest free tag of the pre-edge mask; a tag freed this edge is offered next cycle.
  always_comb begin
    alloc_tag = '0;
    for (int i = NUM_TAGS - 1; i >= 0; i--) begin
      if (!busy_q[i]) alloc_tag = TAG_W'(i);
    end
  end

  assign any_free = ~&busy_q;

  always_comb begin
    busy_d = busy_q;
    if (alloc_en)   busy_d[alloc_tag]   = 1'b1;
    if (release_en) busy_d[release_tag] = 1'b0;
  end

  always_ff @(posedge c_clk) begin
    if (reset) busy_q <= '0;
    else       busy_q <= busy_d;
  end

  assign busy = busy_q;

endmodule

// File: rtl/calc2_req_port.sv
// calc2 requester: accepts ops, drives the two-cycle request, matches responses by tag, retires timeouts.
module calc2_req_port
  import calc2_pkg::*;
#(
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned TAG_W          = 2,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input logic              c_clk,
  input logic              reset,
  calc2_req_port_if.master bus
);

  localparam int unsigned NUM_TAGS = 1 << TAG_W;
  localparam int unsigned CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] AGE_MAX = CNT_W'(TIMEOUT_CYCLES);

  state_e              state_q, state_d;
  logic [TAG_W-1:0]    tag_q, tag_d;
  logic [DATA_W-1:0]   data2_q, data2_d;

  logic [CMD_W-1:0]    req_cmd_q, req_cmd_d;
  logic [DATA_W-1:0]   req_data_q, req_data_d;
  logic [TAG_W-1:0]    req_tag_q, req_tag_d;

  logic                res_valid_q, res_valid_d;
  logic [RESP_W-1:0]   res_resp_q, res_resp_d;
  logic [DATA_W-1:0]   res_data_q, res_data_d;
  logic [TAG_W-1:0]    res_tag_q, res_tag_d;
  logic [CMD_W-1:0]    res_cmd_q, res_cmd_d;
  logic                err_timeout_q, err_timeout_d;
  logic                err_unexpected_q, err_unexpected_d;

  logic [CMD_W-1:0]    cmd_tbl_q [NUM_TAGS];
  logic [CMD_W-1:0]    cmd_tbl_d [NUM_TAGS];
  logic [CNT_W-1:0]    age_q [NUM_TAGS];
  logic [CNT_W-1:0]    age_d [NUM_TAGS];

  logic [TAG_W-1:0]    alloc_tag;
  logic                any_free;
  logic [NUM_TAGS-1:0] busy;
  logic                release_en;
  logic [TAG_W-1:0]    release_tag;

  logic                accept;
  logic                resp_seen;
  logic                resp_hit;
  logic                to_any;
  logic [TAG_W-1:0]    to_tag;

  calc2_tag_pool #(
    .TAG_W (TAG_W)
  ) u_tag_pool (
    .c_clk       (c_clk),
    .reset       (reset),
    .alloc_en    (accept),
    .release_en  (release_en),
    .release_tag (release_tag),
    .alloc_tag   (alloc_tag),
    .any_free    (any_free),
    .busy        (busy)
  );

  // Ready is combinational so a tag freed on one edge can be taken on the next.
  assign bus.op_ready = !reset && (state_q != ST_DRV1) && any_free;
  assign accept       = bus.op_valid && bus.op_ready;

  assign resp_seen = resp_present(bus.resp_in);
  assign resp_hit  = resp_seen && busy[bus.resp_tag_in];

  // Lowest busy tag whose age counter has saturated.
  always_comb begin
    to_any = 1'b0;
    to_tag = '0;
    for (int i = NUM_TAGS - 1; i >= 0; i--) begin
      if (busy[i] && (age_q[i] == AGE_MAX)) begin
        to_any = 1'b1;
        to_tag = TAG_W'(i);
      end
    end
  end

  // Next state and request-pin values for the following cycle.
  always_comb begin
    state_d    = state_q;
    tag_d      = tag_q;
    data2_d    = data2_q;
    cmd_tbl_d  = cmd_tbl_q;
    req_cmd_d  = '0;
    req_data_d = '0;
    req_tag_d  = '0;

    unique case (state_q)
      ST_IDLE, ST_DRV2: begin
        if (accept) begin
          state_d              = ST_DRV1;
          tag_d                = alloc_tag;
          data2_d              = bus.op_data2;
          cmd_tbl_d[alloc_tag] = bus.op_cmd;
          req_cmd_d            = bus.op_cmd;
          req_data_d           = bus.op_data1;
          req_tag_d            = alloc_tag;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DRV1: begin
        state_d    = ST_DRV2;
        req_data_d = data2_q;
        req_tag_d  = tag_q;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Result selection: a matched DUT response wins; a timeout waits for a free slot.
  always_comb begin
    res_valid_d      = 1'b0;
    res_resp_d       = RESP_NONE;
    res_data_d       = '0;
    res_tag_d        = '0;
    res_cmd_d        = '0;
    err_timeout_d    = 1'b0;
    err_unexpected_d = 1'b0;
    release_en       = 1'b0;
    release_tag      = '0;

    if (resp_hit) begin
      res_valid_d = 1'b1;
      res_resp_d  = bus.resp_in;
      res_data_d  = bus.resp_data_in;
      res_tag_d   = bus.resp_tag_in;
      res_cmd_d   = cmd_tbl_q[bus.resp_tag_in];
      release_en  = 1'b1;
      release_tag = bus.resp_tag_in;
    end else if (to_any) begin
      res_valid_d   = 1'b1;
      res_resp_d    = RESP_TIMEOUT;
      res_tag_d     = to_tag;
      res_cmd_d     = cmd_tbl_q[to_tag];
      err_timeout_d = 1'b1;
      release_en    = 1'b1;
      release_tag   = to_tag;
    end

    if (resp_seen && !resp_hit) err_unexpected_d = 1'b1;
  end

  // Per-tag age: cleared on allocation, counts while busy, saturates at the timeout.
  always_comb begin
    age_d = age_q;
    for (int i = 0; i < NUM_TAGS; i++) begin
      if (accept && (alloc_tag == TAG_W'(i))) begin
        age_d[i] = '0;
      end else if (busy[i] && (age_q[i] != AGE_MAX)) begin
        age_d[i] = age_q[i] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge c_clk) begin
    if (reset) begin
      state_q          <= ST_IDLE;
      tag_q            <= '0;
      data2_q          <= '0;
      req_cmd_q        <= '0;
      req_data_q       <= '0;
      req_tag_q        <= '0;
      res_valid_q      <= 1'b0;
      res_resp_q       <= RESP_NONE;
      res_data_q       <= '0;
      res_tag_q        <= '0;
      res_cmd_q        <= '0;
      err_timeout_q    <= 1'b0;
      err_unexpected_q <= 1'b0;
      for (int i = 0; i < NUM_TAGS; i++) begin
        cmd_tbl_q[i] <= '0;
        age_q[i]     <= '0;
      end
    end else begin
      state_q          <= state_d;
      tag_q            <= tag_d;
      data2_q          <= data2_d;
      req_cmd_q        <= req_cmd_d;
      req_data_q       <= req_data_d;
      req_tag_q        <= req_tag_d;
      res_valid_q      <= res_valid_d;
      res_resp_q       <= res_resp_d;
      res_data_q       <= res_data_d;
      res_tag_q        <= res_tag_d;
      res_cmd_q        <= res_cmd_d;
      err_timeout_q    <= err_timeout_d;
      err_unexpected_q <= err_unexpected_d;
      cmd_tbl_q        <= cmd_tbl_d;
      age_q            <= age_d;
    end
  end

  assign bus.req_cmd_out    = req_cmd_q;
  assign bus.req_data_out   = req_data_q;
  assign bus.req_tag_out    = req_tag_q;
  assign bus.res_valid      = res_valid_q;
  assign bus.res_resp       = res_resp_q;
  assign bus.res_data       = res_data_q;
  assign bus.res_tag        = res_tag_q;
  assign bus.res_cmd        = res_cmd_q;
  assign bus.busy_tags      = busy;
  assign bus.err_timeout    = err_timeout_q;
  assign bus.err_unexpected = err_unexpected_q;

endmodule

// File: tb/tb_calc2_req_port.sv
// Directed bench for calc2_req_port: request sequencing, tag reuse, unexpected responses, timeouts, reset.
module tb_calc2_req_port;
  import calc2_pkg::*;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned TAG_W   = 2;
  localparam int unsigned TIMEOUT = 8;

  logic c_clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 c_clk = ~c_clk;

  calc2_req_port_if #(.DATA_W(DATA_W), .TAG_W(TAG_W)) bus ();

  calc2_req_port #(
    .DATA_W         (DATA_W),
    .TAG_W          (TAG_W),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .c_clk (c_clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge c_clk);
    #1;
  endtask

  task automatic set_op(input logic v, input logic [3:0] cmd, input logic [31:0] d1, input logic [31:0] d2);
    bus.op_valid = v;
    bus.op_cmd   = cmd;
    bus.op_data1 = d1;
    bus.op_data2 = d2;
  endtask

  task automatic set_resp(input logic [1:0] r, input logic [31:0] d, input logic [1:0] t);
    bus.resp_in      = r;
    bus.resp_data_in = d;
    bus.resp_tag_in  = t;
  endtask

  task automatic do_reset(input int n);
    set_op(1'b0, 4'd0, 32'd0, 32'd0);
    set_resp(2'd0, 32'd0, 2'd0);
    reset = 1'b1;
    repeat (n) tick();
    reset = 1'b0;
    #1;
  endtask

  initial begin
    logic [3:0] cmds [4];
    cmds[0] = CMD_ADD; cmds[1] = CMD_SUB; cmds[2] = CMD_SHL; cmds[3] = CMD_SHR;

    // Reset state and a single ADD round trip
    set_op(1'b0, 4'd0, 32'd0, 32'd0);
    set_resp(2'd0, 32'd0, 2'd0);
    reset = 1'b1;
    tick();
    check("rst_op_ready", 64'(bus.op_ready), 64'd0);
    tick(); tick();
    check("rst_busy", 64'(bus.busy_tags), 64'd0);
    check("rst_res_valid", 64'(bus.res_valid), 64'd0);
    check("rst_req_cmd", 64'(bus.req_cmd_out), 64'd0);
    check("rst_err_unexp", 64'(bus.err_unexpected), 64'd0);
    reset = 1'b0;
    #1;
    check("post_rst_ready", 64'(bus.op_ready), 64'd1);
    set_op(1'b1, CMD_ADD, 32'd5, 32'd7);
    tick();
    set_op(1'b0, 4'd0, 32'hdead, 32'hbeef);
    check("add_drv1_cmd", 64'(bus.req_cmd_out), 64'd1);
    check("add_drv1_data", 64'(bus.req_data_out), 64'd5);
    check("add_drv1_tag", 64'(bus.req_tag_out), 64'd0);
    check("add_busy", 64'(bus.busy_tags), 64'b0001);
    check("add_drv1_ready", 64'(bus.op_ready), 64'd0);
    tick();
    check("add_drv2_cmd", 64'(bus.req_cmd_out), 64'd0);
    check("add_drv2_data", 64'(bus.req_data_out), 64'd7);
    check("add_drv2_ready", 64'(bus.op_ready), 64'd1);
    tick();
    check("add_idle_data", 64'(bus.req_data_out), 64'd0);
    set_resp(RESP_OK, 32'd12, 2'd0);
    tick();
    set_resp(2'd0, 32'd0, 2'd0);
    check("add_res_valid", 64'(bus.res_valid), 64'd1);
    check("add_res_resp", 64'(bus.res_resp), 64'd1);
    check("add_res_data", 64'(bus.res_data), 64'd12);
    check("add_res_tag", 64'(bus.res_tag), 64'd0);
    check("add_res_cmd", 64'(bus.res_cmd), 64'd1);
    check("add_res_busy", 64'(bus.busy_tags), 64'd0);
    tick();
    check("add_res_pulse", 64'(bus.res_valid), 64'd0);

    // Four back-to-back ops, then release tag 2 while a fifth op waits
    do_reset(1);
    for (int k = 0; k < 4; k++) begin
      set_op(1'b1, cmds[k], 32'(100 + k), 32'(200 + k));
      check($sformatf("b2b_ready_%0d", k), 64'(bus.op_ready), 64'd1);
      tick();
      check($sformatf("b2b_tag_%0d", k), 64'(bus.req_tag_out), 64'(k));
      check($sformatf("b2b_d1_%0d", k), 64'(bus.req_data_out), 64'(100 + k));
      check($sformatf("b2b_drv1_rdy_%0d", k), 64'(bus.op_ready), 64'd0);
      tick();
      check($sformatf("b2b_d2_%0d", k), 64'(bus.req_data_out), 64'(200 + k));
    end
    check("b2b_full_busy", 64'(bus.busy_tags), 64'b1111);
    check("b2b_full_ready", 64'(bus.op_ready), 64'd0);
    set_op(1'b1, CMD_ADD, 32'd500, 32'd600);
    set_resp(RESP_OK, 32'h22, 2'd2);
    tick();
    set_resp(2'd0, 32'd0, 2'd0);
    check("rel2_res_tag", 64'(bus.res_tag), 64'd2);
    check("rel2_res_cmd", 64'(bus.res_cmd), 64'(CMD_SHL));
    check("rel2_res_data", 64'(bus.res_data), 64'h22);
    check("rel2_busy", 64'(bus.busy_tags), 64'b1011);
    check("rel2_req_tag", 64'(bus.req_tag_out), 64'd0);
    check("rel2_ready", 64'(bus.op_ready), 64'd1);
    tick();
    set_op(1'b0, 4'd0, 32'd0, 32'd0);
    check("op5_tag", 64'(bus.req_tag_out), 64'd2);
    check("op5_data", 64'(bus.req_data_out), 64'd500);
    // tag 0 (accepted 9 edges earlier) times out on this same edge
    check("op5_to_resp", 64'(bus.res_resp), 64'd3);
    check("op5_to_tag", 64'(bus.res_tag), 64'd0);
    check("op5_to_err", 64'(bus.err_timeout), 64'd1);
    check("op5_busy", 64'(bus.busy_tags), 64'b1110);

    // Response to a non-busy tag
    do_reset(1);
    set_resp(RESP_OK, 32'h55, 2'd3);
    tick();
    set_resp(2'd0, 32'd0, 2'd0);
    check("unexp_err", 64'(bus.err_unexpected), 64'd1);
    check("unexp_res_valid", 64'(bus.res_valid), 64'd0);
    check("unexp_busy", 64'(bus.busy_tags), 64'd0);
    tick();
    check("unexp_pulse", 64'(bus.err_unexpected), 64'd0);

    // Plain timeout: retired 9 cycles after acceptance
    do_reset(1);
    set_op(1'b1, CMD_SHL, 32'd1, 32'd3);
    tick();
    set_op(1'b0, 4'd0, 32'd0, 32'd0);
    repeat (8) tick();
    check("to_early_valid", 64'(bus.res_valid), 64'd0);
    check("to_early_busy", 64'(bus.busy_tags), 64'b0001);
    tick();
    check("to_valid", 64'(bus.res_valid), 64'd1);
    check("to_resp", 64'(bus.res_resp), 64'd3);
    check("to_data", 64'(bus.res_data), 64'd0);
    check("to_cmd", 64'(bus.res_cmd), 64'(CMD_SHL));
    check("to_err", 64'(bus.err_timeout), 64'd1);
    check("to_busy", 64'(bus.busy_tags), 64'd0);
    tick();
    check("to_pulse", 64'(bus.err_timeout), 64'd0);

    // Response for tag 1 on tag 0's expiry edge defers the timeout
    do_reset(1);
    set_op(1'b1, CMD_SHL, 32'd2, 32'd4);
    tick();
    set_op(1'b1, CMD_ADD, 32'd10, 32'd20);
    tick(); tick();
    set_op(1'b0, 4'd0, 32'd0, 32'd0);
    check("dfr_busy", 64'(bus.busy_tags), 64'b0011);
    repeat (6) tick();
    set_resp(RESP_ERR, 32'h77, 2'd1);
    tick();
    set_resp(2'd0, 32'd0, 2'd0);
    check("dfr_res_tag", 64'(bus.res_tag), 64'd1);
    check("dfr_res_resp", 64'(bus.res_resp), 64'd2);
    check("dfr_res_cmd", 64'(bus.res_cmd), 64'(CMD_ADD));
    check("dfr_no_to", 64'(bus.err_timeout), 64'd0);
    check("dfr_busy1", 64'(bus.busy_tags), 64'b0001);
    tick();
    check("dfr_to_resp", 64'(bus.res_resp), 64'd3);
    check("dfr_to_tag", 64'(bus.res_tag), 64'd0);
    check("dfr_to_cmd", 64'(bus.res_cmd), 64'(CMD_SHL));
    check("dfr_to_err", 64'(bus.err_timeout), 64'd1);
    check("dfr_busy0", 64'(bus.busy_tags), 64'd0);

    // Reset asserted during DRV2
    do_reset(1);
    set_op(1'b1, CMD_SUB, 32'h11, 32'h22);
    tick();
    set_op(1'b0, 4'd0, 32'd0, 32'd0);
    tick();
    check("mrst_drv2_data", 64'(bus.req_data_out), 64'h22);
    reset = 1'b1;
    set_resp(RESP_OK, 32'h99, 2'd0);
    #1;
    check("mrst_ready", 64'(bus.op_ready), 64'd0);
    tick();
    set_resp(2'd0, 32'd0, 2'd0);
    check("mrst_req_cmd", 64'(bus.req_cmd_out), 64'd0);
    check("mrst_req_data", 64'(bus.req_data_out), 64'd0);
    check("mrst_req_tag", 64'(bus.req_tag_out), 64'd0);
    check("mrst_res_valid", 64'(bus.res_valid), 64'd0);
    check("mrst_res_data", 64'(bus.res_data), 64'd0);
    check("mrst_busy", 64'(bus.busy_tags), 64'd0);
    reset = 1'b0;
    #1;
    check("mrst_ready_rel", 64'(bus.op_ready), 64'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
